// File: rtl/pipe_arb2.sv
// rtl/pipe_arb2.sv - round-robin two-source arbiter feeding a four-phase pipeline input
//
// Optional watchdog: define PIPE_ARB_WDOG_EN to build the REQ_HI/REQ_LO cycle
// counter and the sticky wdog_err flag; otherwise wdog_err is tied low.
//
// Ports:
//   clk        in   single clock for all state
//   rst        in   asynchronous active-low reset
//   src0_req   in   source 0 four-phase request (synchronous to clk)
//   src0_data  in   source 0 word, stable while src0_req=1
//   src0_ack   out  source 0 four-phase acknowledge
//   src1_req   in   source 1 four-phase request (synchronous to clk)
//   src1_data  in   source 1 word, stable while src1_req=1
//   src1_ack   out  source 1 four-phase acknowledge
//   pipe_req   out  request into the pipeline input
//   pipe_data  out  data into the pipeline input, held from grant to next grant
//   pipe_ack   in   pipeline input acknowledge (asynchronous)
//   grant_id   out  source currently or last granted
//   busy       out  high whenever the FSM is not IDLE
//   xfer_cnt   out  completed transfers, wrapping
//   wdog_err   out  sticky watchdog flag
module pipe_arb2 #(
  parameter int DW          = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          src0_req,
  input  logic [DW-1:0] src0_data,
  output logic          src0_ack,
  input  logic          src1_req,
  input  logic [DW-1:0] src1_data,
  output logic          src1_ack,
  output logic          pipe_req,
  output logic [DW-1:0] pipe_data,
  input  logic          pipe_ack,
  output logic          grant_id,
  output logic          busy,
  output logic [7:0]    xfer_cnt,
  output logic          wdog_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_HI  = 2'd1,
    REQ_LO  = 2'd2,
    SRC_ACK = 2'd3
  } state_t;

  // The FSM flop that acts on ack_s is the last synchronizer stage, so only
  // SYNC_STAGES-1 dedicated flops precede it. This gives SYNC_STAGES edges
  // from a pipe_ack change to the FSM reacting to it.
  localparam int SW = SYNC_STAGES - 1;

  state_t         state;
  logic           prio;
  logic [SW-1:0]  ack_sync;
  logic           ack_s;
  logic           gnt_fire;
  logic           gnt_id;
  logic           granted_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_sync <= '0;
    end else begin
      ack_sync[0] <= pipe_ack;
      for (int i = 1; i < SW; i++) begin
        ack_sync[i] <= ack_sync[i-1];
      end
    end
  end

  assign ack_s = ack_sync[SW-1];

  // A stale pipe_ack in IDLE simply blocks the grant until it clears.
  assign gnt_fire    = (state == IDLE) && !ack_s && (src0_req || src1_req);
  // Both requesting: prio decides; otherwise whichever one is asking.
  assign gnt_id      = (src0_req && src1_req) ? prio : src1_req;
  assign granted_req = grant_id ? src1_req : src0_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      pipe_req  <= 1'b0;
      pipe_data <= '0;
      src0_ack  <= 1'b0;
      src1_ack  <= 1'b0;
      grant_id  <= 1'b0;
      busy      <= 1'b0;
      xfer_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_fire) begin
            grant_id  <= gnt_id;
            pipe_data <= gnt_id ? src1_data : src0_data;
            pipe_req  <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            pipe_req <= 1'b0;
            state    <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            if (grant_id) begin
              src1_ack <= 1'b1;
            end else begin
              src0_ack <= 1'b1;
            end
            xfer_cnt <= xfer_cnt + 8'd1;
            state    <= SRC_ACK;
          end
        end
        SRC_ACK: begin
          // Round-robin advances only once the granted source has released.
          if (!granted_req) begin
            src0_ack <= 1'b0;
            src1_ack <= 1'b0;
            prio     <= ~grant_id;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PIPE_ARB_WDOG_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WDOG_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wdog_cnt;
  logic          in_xfer;

  assign in_xfer = (state == REQ_HI) || (state == REQ_LO);

  // Counts cycles spent in the pipeline handshake; saturates so the flag
  // cannot be re-armed by wrap-around. The transfer itself is never aborted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (gnt_fire) begin
        wdog_cnt <= '0;
      end else if (in_xfer && (wdog_cnt != WDOG_MAX)) begin
        wdog_cnt <= wdog_cnt + 1'b1;
        if (wdog_cnt == WDOG_LAST) begin
          wdog_err <= 1'b1;
        end
      end
    end
  end
`else
  // TIMEOUT only matters when the watchdog is built.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wdog_err       = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_arb2.sv
// tb/tb_pipe_arb2.sv - scoreboard bench for pipe_arb2
module tb_pipe_arb2;

  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          src0_req = 1'b0;
  logic [DW-1:0] src0_data = '0;
  logic          src0_ack;
  logic          src1_req = 1'b0;
  logic [DW-1:0] src1_data = '0;
  logic          src1_ack;
  logic          pipe_req;
  logic [DW-1:0] pipe_data;
  logic          pipe_ack = 1'b0;
  logic          grant_id;
  logic          busy;
  logic [7:0]    xfer_cnt;
  logic          wdog_err;

  pipe_arb2 #(.DW(DW), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .src0_req  (src0_req),
    .src0_data (src0_data),
    .src0_ack  (src0_ack),
    .src1_req  (src1_req),
    .src1_data (src1_data),
    .src1_ack  (src1_ack),
    .pipe_req  (pipe_req),
    .pipe_data (pipe_data),
    .pipe_ack  (pipe_ack),
    .grant_id  (grant_id),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt),
    .wdog_err  (wdog_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  logic resp_en = 1'b0;
  int   ack_dly = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic id, input logic [DW-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  // Pipeline model: pops the expected grant when pipe_req rises, then runs
  // the four-phase handshake with a programmable ack delay.
  initial begin
    int            rs;
    int            w;
    logic [DW-1:0] held;
    exp_t          e;
    rs = 0;
    w = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        rs = 0;
      end else begin
        case (rs)
          0: if (pipe_req) begin
            if (sb.size() == 0) begin
              chk("sb_underflow", 1, 0);
            end else begin
              e = sb.pop_front();
              chk("pipe_data", pipe_data, e.data);
              chk("grant_id", grant_id, e.id);
            end
            held = pipe_data;
            w = ack_dly;
            rs = 1;
          end
          1: begin
            chk("data_stable", pipe_data, held);
            if (w == 0) begin
              pipe_ack = 1'b1;
              rs = 2;
            end else begin
              w--;
            end
          end
          default: if (!pipe_req) begin
            pipe_ack = 1'b0;
            rs = 0;
          end
        endcase
      end
    end
  end

  // Only the granted source may ever be acknowledged.
  always @(negedge clk) begin
    if (src0_ack || src1_ack) begin
      chk("ack_excl", src0_ack & src1_ack, 0);
      chk("ack_owner", src1_ack, grant_id);
    end
  end

  task automatic src_xfer(input logic id, input logic [DW-1:0] d, input int hold);
    int t;
    if (id) begin
      src1_data = d;
      src1_req  = 1'b1;
    end else begin
      src0_data = d;
      src0_req  = 1'b1;
    end
    t = 0;
    while (!(id ? src1_ack : src0_ack) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("ack_rise_timeout", 1, 0);
    repeat (hold) @(negedge clk);
    if (id) src1_req = 1'b0;
    else    src0_req = 1'b0;
    t = 0;
    while ((id ? src1_ack : src0_ack) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("ack_fall_timeout", 1, 0);
  endtask

  task automatic do_reset();
    resp_en   = 1'b0;
    pipe_ack  = 1'b0;
    src0_req  = 1'b0;
    src1_req  = 1'b0;
    src0_data = '0;
    src1_data = '0;
    rst       = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    int t;
    int t0;

    // Reset values
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pipe_req", pipe_req, 0);
    chk("rst_pipe_data", pipe_data, 0);
    chk("rst_src0_ack", src0_ack, 0);
    chk("rst_src1_ack", src1_ack, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_wdog_err", wdog_err, 0);

    // Single source, pipeline acks after 3 cycles
    do_reset();
    resp_en = 1'b1;
    ack_dly = 3;
    push(1'b0, 3'b101);
    src_xfer(1'b0, 3'b101, 0);
    chk("single_xfer_cnt", xfer_cnt, 1);
    chk("single_grant_id", grant_id, 0);
    chk("single_busy", busy, 0);
    chk("single_sb_empty", sb.size(), 0);

    // Contention: both sources keep requesting, grants must alternate
    do_reset();
    resp_en = 1'b1;
    ack_dly = 0;
    push(1'b0, 3'd1);
    push(1'b1, 3'd6);
    push(1'b0, 3'd1);
    push(1'b1, 3'd6);
    fork
      begin repeat (2) src_xfer(1'b0, 3'd1, 0); end
      begin repeat (2) src_xfer(1'b1, 3'd6, 0); end
    join
    chk("cont_xfer_cnt", xfer_cnt, 4);
    chk("cont_sb_empty", sb.size(), 0);

    // Stale ack held in IDLE blocks the grant until it has been synchronized low
    do_reset();
    pipe_ack = 1'b1;
    repeat (3) @(negedge clk);
    src1_data = 3'd2;
    src1_req  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stale_no_grant", pipe_req, 0);
    end
    push(1'b1, 3'd2);
    pipe_ack = 1'b0;
    t0 = cyc;
    resp_en = 1'b1;
    t = 0;
    while (!pipe_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("stale_latency", cyc - t0, 2);
    chk("stale_grant_id", grant_id, 1);
    src_xfer(1'b1, 3'd2, 0);
    chk("stale_xfer_cnt", xfer_cnt, 1);

    // Reset asserted while in REQ_HI
    do_reset();
    resp_en = 1'b1;
    ack_dly = 20;
    push(1'b0, 3'd3);
    src0_data = 3'd3;
    src0_req  = 1'b1;
    t = 0;
    while (!pipe_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("mid_pre_busy", busy, 1);
    chk("mid_pre_pipe_req", pipe_req, 1);
    rst = 1'b0;
    resp_en = 1'b0;
    #1;
    chk("mid_pipe_req", pipe_req, 0);
    chk("mid_src0_ack", src0_ack, 0);
    chk("mid_src1_ack", src1_ack, 0);
    chk("mid_busy", busy, 0);
    chk("mid_xfer_cnt", xfer_cnt, 0);
    chk("mid_wdog_err", wdog_err, 0);
    pipe_ack = 1'b0;
    src0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    resp_en = 1'b1;
    ack_dly = 2;
    push(1'b1, 3'd4);
    src_xfer(1'b1, 3'd4, 0);
    chk("mid_after_xfer_cnt", xfer_cnt, 1);
    chk("mid_sb_empty", sb.size(), 0);

    // Slow release by src0 with src1 pending
    do_reset();
    resp_en = 1'b1;
    ack_dly = 1;
    push(1'b0, 3'd7);
    push(1'b1, 3'd2);
    fork
      src_xfer(1'b0, 3'd7, 10);
      begin
        repeat (2) @(negedge clk);
        src_xfer(1'b1, 3'd2, 0);
      end
      begin
        int tt;
        int tf;
        tt = 0;
        while (!src0_ack && tt < 100) begin
          @(negedge clk);
          tt++;
        end
        while (src0_ack && tt < 200) begin
          chk("slow_no_early_grant", pipe_req, 0);
          @(negedge clk);
          tt++;
        end
        tf = cyc;
        while (!pipe_req && tt < 300) begin
          @(negedge clk);
          tt++;
        end
        chk("slow_timeout", (tt >= 300) ? 1 : 0, 0);
        chk("slow_release_to_grant", cyc - tf, 1);
        chk("slow_grant_id", grant_id, 1);
      end
    join
    chk("slow_xfer_cnt", xfer_cnt, 2);
    chk("slow_sb_empty", sb.size(), 0);

    // Pipeline never acks: FSM keeps waiting, watchdog fires when built
    do_reset();
    src0_data = 3'd1;
    src0_req  = 1'b1;
    t = 0;
    while (!pipe_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    chk("wdog_early", wdog_err, 0);
    repeat (10) @(negedge clk);
`ifdef PIPE_ARB_WDOG_EN
    chk("wdog_set", wdog_err, 1);
    repeat (5) @(negedge clk);
    chk("wdog_sticky", wdog_err, 1);
`else
    chk("wdog_tied", wdog_err, 0);
`endif
    chk("wdog_pipe_req", pipe_req, 1);
    chk("wdog_busy", busy, 1);
    do_reset();
    chk("wdog_after_rst", wdog_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
